// File: rtl/trigger_sequencer.sv
// Multi-stage sequential trigger: per-stage level/edge conditions with occurrence
// counts, evaluated in order; emits a one-cycle run pulse when the last stage completes.
module trigger_sequencer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int NUM_STAGES   = 4,
    parameter int COUNT_WIDTH  = 16,
    localparam int STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic                    cfg_we,
    input  logic [STAGE_W-1:0]      cfg_stage,
    input  logic [2:0]              cfg_sel,
    input  logic [31:0]             cfg_data,
    output logic                    run,
    output logic                    armed,
    output logic                    triggered,
    output logic [STAGE_W-1:0]      stage
);

    localparam int NSW = $clog2(NUM_STAGES + 1);
    localparam logic [NSW-1:0] NS_MAX    = NSW'(NUM_STAGES);
    localparam logic [31:0]    NS_MAX_32 = 32'(NUM_STAGES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [STAGE_W-1:0]        stage_r, stage_nxt_s;
    logic [COUNT_WIDTH-1:0]    cnt_r, cnt_nxt_s, cnt_inc_s, cnt_eff_s;
    logic [SAMPLE_WIDTH-1:0]   prev_r, prev_nxt_s;
    logic                      prev_valid_r, prev_valid_nxt_s;
    logic                      fire_s, match_s, last_stage_s;
    logic                      run_r, armed_r, triggered_r;
    logic                      run_nxt_s, armed_nxt_s, triggered_nxt_s;

    logic [SAMPLE_WIDTH-1:0]   value_r [NUM_STAGES];
    logic [SAMPLE_WIDTH-1:0]   mask_r  [NUM_STAGES];
    logic [SAMPLE_WIDTH-1:0]   rise_r  [NUM_STAGES];
    logic [SAMPLE_WIDTH-1:0]   fall_r  [NUM_STAGES];
    logic [COUNT_WIDTH-1:0]    count_r [NUM_STAGES];
    logic [NSW-1:0]            num_stages_r, ns_clamp_s;
    logic                      cfg_wr_s, cfg_stage_ok_s;

    // Edge bits demand a known previous sample, so nothing with rise/fall matches first.
    function automatic logic stage_match(
        input logic [SAMPLE_WIDTH-1:0] data,
        input logic [SAMPLE_WIDTH-1:0] prev,
        input logic                    pvalid,
        input logic [SAMPLE_WIDTH-1:0] value,
        input logic [SAMPLE_WIDTH-1:0] mask,
        input logic [SAMPLE_WIDTH-1:0] rise,
        input logic [SAMPLE_WIDTH-1:0] fall
    );
        logic [SAMPLE_WIDTH-1:0] rose, fell;
        rose = pvalid ? (~prev & data) : {SAMPLE_WIDTH{1'b0}};
        fell = pvalid ? (prev & ~data) : {SAMPLE_WIDTH{1'b0}};
        return (((data ^ value) & mask) == {SAMPLE_WIDTH{1'b0}}) &&
               ((rise & ~rose) == {SAMPLE_WIDTH{1'b0}}) &&
               ((fall & ~fell) == {SAMPLE_WIDTH{1'b0}});
    endfunction

    assign cfg_wr_s       = cfg_we && !arm && !disarm && (state_r != ST_ARMED);
    assign cfg_stage_ok_s = (NSW + 1)'(cfg_stage) < (NSW + 1)'(NS_MAX);
    assign match_s        = stage_match(dataIn, prev_r, prev_valid_r, value_r[stage_r],
                                        mask_r[stage_r], rise_r[stage_r], fall_r[stage_r]);
    assign cnt_eff_s      = (count_r[stage_r] == {COUNT_WIDTH{1'b0}}) ?
                            COUNT_WIDTH'(1'b1) : count_r[stage_r];
    assign cnt_inc_s      = (cnt_r == {COUNT_WIDTH{1'b1}}) ? cnt_r : cnt_r + COUNT_WIDTH'(1'b1);
    assign last_stage_s   = ((NSW + 1)'(stage_r) + (NSW + 1)'(1'b1)) >= (NSW + 1)'(num_stages_r);

    // Clamp the requested stage count into 1..NUM_STAGES.
    always_comb begin
        if (cfg_data == 32'd0) begin
            ns_clamp_s = NSW'(1'b1);
        end else if (cfg_data > NS_MAX_32) begin
            ns_clamp_s = NS_MAX;
        end else begin
            ns_clamp_s = cfg_data[NSW-1:0];
        end
    end

    // Configuration registers; only written while not armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                value_r[i] <= {SAMPLE_WIDTH{1'b0}};
                mask_r[i]  <= {SAMPLE_WIDTH{1'b0}};
                rise_r[i]  <= {SAMPLE_WIDTH{1'b0}};
                fall_r[i]  <= {SAMPLE_WIDTH{1'b0}};
                count_r[i] <= {COUNT_WIDTH{1'b0}};
            end
            num_stages_r <= NSW'(1'b1);
        end else if (cfg_wr_s) begin
            case (cfg_sel)
                3'd0: if (cfg_stage_ok_s) value_r[cfg_stage] <= cfg_data[SAMPLE_WIDTH-1:0];
                3'd1: if (cfg_stage_ok_s) mask_r[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
                3'd2: if (cfg_stage_ok_s) rise_r[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
                3'd3: if (cfg_stage_ok_s) fall_r[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
                3'd4: if (cfg_stage_ok_s) count_r[cfg_stage] <= cfg_data[COUNT_WIDTH-1:0];
                3'd5: num_stages_r <= ns_clamp_s;
                default: ;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            stage_r      <= {STAGE_W{1'b0}};
            cnt_r        <= {COUNT_WIDTH{1'b0}};
            prev_r       <= {SAMPLE_WIDTH{1'b0}};
            prev_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            stage_r      <= stage_nxt_s;
            cnt_r        <= cnt_nxt_s;
            prev_r       <= prev_nxt_s;
            prev_valid_r <= prev_valid_nxt_s;
        end
    end

    // Next-state logic: disarm beats arm, and either one suppresses sample evaluation.
    always_comb begin
        state_nxt_s      = state_r;
        stage_nxt_s      = stage_r;
        cnt_nxt_s        = cnt_r;
        prev_nxt_s       = prev_r;
        prev_valid_nxt_s = prev_valid_r;
        fire_s           = 1'b0;
        if (disarm) begin
            state_nxt_s = ST_IDLE;
        end else if (arm) begin
            state_nxt_s      = ST_ARMED;
            stage_nxt_s      = {STAGE_W{1'b0}};
            cnt_nxt_s        = {COUNT_WIDTH{1'b0}};
            prev_valid_nxt_s = 1'b0;
        end else if ((state_r == ST_ARMED) && valid) begin
            prev_nxt_s       = dataIn;
            prev_valid_nxt_s = 1'b1;
            if (match_s && (cnt_inc_s >= cnt_eff_s) && last_stage_s) begin
                state_nxt_s = ST_FIRED;
                cnt_nxt_s   = cnt_inc_s;
                fire_s      = 1'b1;
            end else if (match_s && (cnt_inc_s >= cnt_eff_s)) begin
                stage_nxt_s = stage_r + STAGE_W'(1'b1);
                cnt_nxt_s   = {COUNT_WIDTH{1'b0}};
            end else if (match_s) begin
                cnt_nxt_s = cnt_inc_s;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output decode from the upcoming state.
    always_comb begin
        run_nxt_s = fire_s;
        case (state_nxt_s)
            ST_IDLE:  begin armed_nxt_s = 1'b0; triggered_nxt_s = 1'b0; end
            ST_ARMED: begin armed_nxt_s = 1'b1; triggered_nxt_s = 1'b0; end
            ST_FIRED: begin armed_nxt_s = 1'b0; triggered_nxt_s = 1'b1; end
            default:  begin armed_nxt_s = 1'b0; triggered_nxt_s = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_r       <= 1'b0;
            armed_r     <= 1'b0;
            triggered_r <= 1'b0;
        end else begin
            run_r       <= run_nxt_s;
            armed_r     <= armed_nxt_s;
            triggered_r <= triggered_nxt_s;
        end
    end

    assign run       = run_r;
    assign armed     = armed_r;
    assign triggered = triggered_r;
    assign stage     = stage_r;

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Parametrised multi-stage trigger for the AC1 logic analyzer and successor to the single-condition trigger. Each sample carries per-stage level (value/mask) and edge (rising/falling) conditions plus an occurrence count, and stages are evaluated in sequence. When the last enabled stage completes, `run` pulses to start the capture controller. It sits between the sample front end (`dataIn`/`valid`) and the capture controller, which configures it over a small register port.

## Interface
- `SAMPLE_WIDTH`, 8: channels per sample (1..32).
- `NUM_STAGES`, 4: stages implemented (1..16).
- `COUNT_WIDTH`, 16: occurrence counter width (1..32).
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state and configuration.
- `valid` in 1: `dataIn` holds a new sample this cycle.
- `dataIn` in SAMPLE_WIDTH: sample channels.
- `arm` in 1: level-sampled; high for one cycle starts or restarts the sequence at stage 0.
- `disarm` in 1: returns to IDLE.
- `cfg_we` in 1: configuration write strobe.
- `cfg_stage` in max(1,clog2(NUM_STAGES)): target stage.
- `cfg_sel` in 3: 0 value, 1 mask, 2 rise, 3 fall, 4 count, 5 num_stages (`cfg_stage` ignored); 6..7 ignored.
- `cfg_data` in 32: write data, LSB-aligned.
- `run` out 1: one-cycle trigger pulse.
- `armed` out 1: high in ARMED.
- `triggered` out 1: high in FIRED.
- `stage` out max(1,clog2(NUM_STAGES)): current stage index.

## Operation
- States: IDLE (reset), ARMED, FIRED. IDLE/FIRED -arm-> ARMED, stage 0, counter 0, prev_valid 0. ARMED -arm-> ARMED (restart as above). ARMED -final match-> FIRED. Any state -disarm-> IDLE.
- Priority each cycle: reset > disarm > arm > cfg_we > sample evaluation. A cycle with `arm` or `disarm` does not evaluate or record the sample.
- Config writes are accepted only in IDLE or FIRED and are ignored in ARMED. Writes to `cfg_stage` >= NUM_STAGES are ignored.
- num_stages write: 0 stores 1; values > NUM_STAGES store NUM_STAGES. Reset value 1.
- Count register: 0 is treated as 1. Reset value 0.
- value/mask/rise/fall reset to 0, so a reset-configured stage matches every valid sample.
- Previous-sample register `prev` loads `dataIn` on every valid cycle in ARMED. `prev_valid` is set on the first such load.
- Stage k match on a valid cycle in ARMED, requiring all of:
  - `((dataIn ^ value) & mask) == 0`
  - for every bit set in rise: `prev_valid`, `prev`=0, `dataIn`=1
  - for every bit set in fall: `prev_valid`, `prev`=1, `dataIn`=0
- A stage with any rise/fall bit never matches the first valid sample after arm.
- On each match the counter increments. Matches need not be consecutive; non-matching samples do not clear the counter.
- When the counter reaches the stage count:
  - if k < num_stages-1: stage becomes k+1 and the counter clears. The same sample is not re-evaluated against stage k+1.
  - otherwise: go to FIRED.
- The counter saturates at all-ones and never wraps.
- FIRED holds `stage` at its last value until arm, disarm or reset.

## Timing
- Reset values: `run` 0, `armed` 0, `triggered` 0, `stage` 0, state IDLE, counter 0, `prev_valid` 0.
- `armed` rises the cycle after the `arm` edge.
- Final match captured at edge N:
  - `triggered` is high and `run` is high from N+1.
  - `run` drops at N+2 (exactly one cycle wide).
  - `armed` is low from N+1.
- Stage advance captured at edge N: `stage` shows k+1 from N+1.
- Config writes take effect for samples evaluated on the cycle after the write edge.
- Sample rate: up to one sample per clock. `valid` low cycles are skipped without effect.
- Reset mid-sequence: next cycle IDLE with all outputs 0 and configuration cleared.

## Test plan
- Reset then arm; `valid`=1 with any `dataIn` -> `run` pulses one cycle at N+1; `triggered`=1, `armed`=0.
- Stage 0 rise=0x01, count=1; `dataIn` 0x00, 0x01 -> fires on the second sample. Sequence 0x01 as the first sample after arm -> no fire.
- Two stages: stage 0 value=0xA5 mask=0xFF count=3; stage 1 fall=0x80; num_stages=2. Stimulus: 0xA5, 0x00, 0xA5, 0xA5, 0xFF, 0x7F -> `stage` 1 after the third 0xA5, `run` after 0x7F.
- Arm while ARMED at stage 1 -> `stage` 0, counter cleared, no `run`. `disarm` while ARMED -> `armed`=0, no `run` for any subsequent data.
- `cfg_we` in ARMED changing mask -> ignored (old match behaviour retained). num_stages writes of 0 and 9 (NUM_STAGES=4) -> read back as 1 and 4 via the observed stage sequence.
- Count=0 behaves as 1. `reset` asserted in the same cycle as a final match -> `run` stays 0, all outputs 0.
